// File: rtl/tfr_hs_responder_pkg.sv
// Shared constants for the four-phase CDC responder: FSM encoding and counter width.
package tfr_hs_responder_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam int         XFER_W  = 16;
endpackage

// File: rtl/tfr_sync_fifo.sv
// Single-clock FIFO, show-ahead: head entry is always driven from storage flops.
module tfr_sync_fifo #(
  parameter int W      = 32,
  parameter int LGFIFO = 1
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rd_data
);
  localparam int DEPTH = 1 << LGFIFO;
  localparam logic [LGFIFO:0] DEPTH_C = {1'b1, {LGFIFO{1'b0}}};

  logic [W-1:0]      mem [DEPTH];
  logic [LGFIFO-1:0] wptr, rptr;
  logic [LGFIFO:0]   cnt;
  logic              do_wr, do_rd;

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign do_wr   = wr && !full;
  assign do_rd   = rd && !empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) begin
        mem[wptr] <= wr_data;
        wptr      <= wptr + LGFIFO'(1);
      end
      if (do_rd) rptr <= rptr + LGFIFO'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (LGFIFO+1)'(1);
        2'b01:   cnt <= cnt - (LGFIFO+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  a_occupancy: assert property (@(posedge i_clk) disable iff (!i_reset_n) cnt <= DEPTH_C);
endmodule

// File: rtl/tfr_hs_responder.sv
// Receiving end of a four-phase req/ack CDC handshake feeding a valid/ready stream.
module tfr_hs_responder
  import tfr_hs_responder_pkg::*;
#(
  parameter int W      = 32,
  parameter int NFF    = 2,
  parameter int LGFIFO = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req,
  input  logic [W-1:0]      i_data,
  output logic              o_ack,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W-1:0]      o_data,
  output logic [XFER_W-1:0] o_xfers
);
  logic [NFF-1:0] sync;
  logic           s_req;
  logic [0:0]     state;
  logic           full, empty, capture;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) sync <= '0;
    else            sync <= {sync[NFF-2:0], i_req};
  end
  assign s_req = sync[NFF-1];

  // Ack is withheld while full; that is the only back-pressure the requester sees.
  assign capture = (state == ST_IDLE) && s_req && !full;
  assign o_ack   = (state == ST_HOLD);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      o_xfers <= '0;
    end else if (capture) begin
      state   <= ST_HOLD;
      o_xfers <= o_xfers + XFER_W'(1);
    end else if (state == ST_HOLD && !s_req) begin
      state   <= ST_IDLE;
    end
  end

  tfr_sync_fifo #(.W(W), .LGFIFO(LGFIFO)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .wr        (capture),
    .wr_data   (i_data),
    .rd        (i_ready),
    .full      (full),
    .empty     (empty),
    .rd_data   (o_data)
  );
  assign o_valid = !empty;

  a_ack_fall:  assert property (@(posedge i_clk) disable iff (!i_reset_n)
                 $fell(o_ack) |-> !$past(s_req));
  a_cap_idle:  assert property (@(posedge i_clk) disable iff (!i_reset_n)
                 capture |-> !o_ack);
  a_cap_ack:   assert property (@(posedge i_clk) disable iff (!i_reset_n)
                 capture |=> o_ack);
  a_stall:     assert property (@(posedge i_clk) disable iff (!i_reset_n)
                 (o_valid && !i_ready) |=> (o_valid && $stable(o_data)));
endmodule

// File: tb/tb_tfr_hs_responder.sv
// Bench for tfr_hs_responder: vector table, directed corner sequences, random traffic vs a queue model.
module tb_tfr_hs_responder;
  localparam int W = 32, NFF = 2, LGFIFO = 1, DEPTH = 1 << LGFIFO;

  logic          i_clk = 1'b0, i_reset_n = 1'b1, i_req = 1'b0, i_ready = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          o_ack, o_valid;
  logic [W-1:0]  o_data;
  logic [15:0]   o_xfers;

  always #5 i_clk = ~i_clk;

  tfr_hs_responder #(.W(W), .NFF(NFF), .LGFIFO(LGFIFO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req(i_req), .i_data(i_data),
    .o_ack(o_ack), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_xfers(o_xfers)
  );

  int checks = 0, errors = 0;

  // Model: i_req seen NFF edges late, one capture per ack cycle, words in a queue.
  bit           hist [NFF];
  bit           ack_m;
  logic [W-1:0] q [$];
  logic [W-1:0] popped [$];
  int unsigned  xfers_m;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NFF; i++) hist[i] = 1'b0;
    ack_m = 1'b0;
    q.delete();
    xfers_m = 0;
  endtask

  task automatic model_edge();
    bit sreq, cap, pop;
    sreq = hist[NFF-1];
    cap  = !ack_m && sreq && (q.size() < DEPTH);
    pop  = (q.size() > 0) && i_ready;
    if (pop) void'(q.pop_front());
    if (cap) begin q.push_back(i_data); xfers_m++; end
    if (cap) ack_m = 1'b1;
    else if (!sreq) ack_m = 1'b0;
    for (int i = NFF-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = i_req;
  endtask

  task automatic check_model();
    chk("ack", 32'(o_ack), 32'(ack_m));
    chk("valid", 32'(o_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("data", o_data, q[0]);
    chk("xfers", 32'(o_xfers), 32'(16'(xfers_m)));
  endtask

  task automatic tick();
    if (o_valid && i_ready) popped.push_back(o_data);
    model_edge();
    @(posedge i_clk); #1;
    check_model();
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    model_reset();
    #2;
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_xfers", 32'(o_xfers), 32'd0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    popped.delete();
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    i_data = d; i_req = 1'b1; n = 0;
    while (!o_ack && n < 20) begin tick(); n++; end
    chk("send_ack_rise", 32'(n < 20), 32'd1);
    i_req = 1'b0; n = 0;
    while (o_ack && n < 20) begin tick(); n++; end
    chk("send_ack_fall", 32'(n < 20), 32'd1);
  endtask

  typedef struct {
    bit           req;
    bit           ready;
    logic [W-1:0] data;
    bit           ack;
    bit           valid;
    logic [W-1:0] odata;
    logic [15:0]  xfers;
  } vec_t;
  vec_t tbl [7];

  initial begin
    int n;
    // Single transfer: ack two edges after req rise, falls two edges after req drop.
    tbl[0] = '{1, 1, 32'hA5A5_0001, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 32'hA5A5_0001, 0, 0, 0, 0};
    tbl[2] = '{1, 1, 32'hA5A5_0001, 1, 1, 32'hA5A5_0001, 1};
    tbl[3] = '{0, 1, 32'hA5A5_0001, 1, 0, 0, 1};
    tbl[4] = '{0, 1, 32'hA5A5_0001, 1, 0, 0, 1};
    tbl[5] = '{0, 1, 32'hA5A5_0001, 0, 0, 0, 1};
    tbl[6] = '{0, 1, 32'hA5A5_0001, 0, 0, 0, 1};

    #1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      i_req = tbl[i].req; i_ready = tbl[i].ready; i_data = tbl[i].data;
      tick();
      chk($sformatf("vec%0d_ack", i), 32'(o_ack), 32'(tbl[i].ack));
      chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("vec%0d_data", i), o_data, tbl[i].odata);
      chk($sformatf("vec%0d_xfers", i), 32'(o_xfers), 32'(tbl[i].xfers));
    end

    // Back-pressure: third request waits for space, order preserved.
    do_reset();
    i_ready = 1'b0;
    send(32'd1);
    send(32'd2);
    i_data = 32'd3; i_req = 1'b1;
    repeat (6) begin tick(); chk("bp_ack_held", 32'(o_ack), 32'd0); end
    i_ready = 1'b1;
    tick(); chk("bp_no_ack_yet", 32'(o_ack), 32'd0);
    tick(); chk("bp_ack_after_space", 32'(o_ack), 32'd1);
    i_req = 1'b0;
    repeat (8) tick();
    chk("bp_pop_count", 32'(popped.size()), 32'd3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      chk($sformatf("bp_pop%0d", i), popped[i], 32'(i + 1));

    // Stall stability.
    do_reset();
    i_ready = 1'b0;
    send(32'h0000_00FF);
    repeat (10) begin
      tick();
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_data", o_data, 32'h0000_00FF);
    end
    i_ready = 1'b1;
    tick(); chk("stall_drained", 32'(o_valid), 32'd0);

    // Write and pop on the same edge with one entry held.
    do_reset();
    i_ready = 1'b0;
    send(32'h11);
    i_data = 32'h22; i_req = 1'b1;
    tick(); tick();
    i_ready = 1'b1;
    tick();
    chk("wp_ack", 32'(o_ack), 32'd1);
    chk("wp_valid", 32'(o_valid), 32'd1);
    chk("wp_head", o_data, 32'h22);
    i_ready = 1'b0; i_req = 1'b0;
    tick();
    chk("wp_one_left", 32'(o_valid), 32'd1);
    i_ready = 1'b1;
    tick();
    chk("wp_empty", 32'(o_valid), 32'd0);
    chk("wp_pop_count", 32'(popped.size()), 32'd2);
    if (popped.size() == 2) begin
      chk("wp_pop0", popped[0], 32'h11);
      chk("wp_pop1", popped[1], 32'h22);
    end
    repeat (4) tick();

    // Reset while holding ack with a full FIFO; req stays high across it.
    do_reset();
    i_ready = 1'b0;
    send(32'hA1);
    i_data = 32'hA2; i_req = 1'b1; n = 0;
    while (!o_ack && n < 20) begin tick(); n++; end
    chk("rh_in_hold", 32'(o_ack), 32'd1);
    chk("rh_two_words", 32'(o_xfers), 32'd2);
    i_reset_n = 1'b0;
    model_reset();
    #1;
    chk("rh_ack", 32'(o_ack), 32'd0);
    chk("rh_valid", 32'(o_valid), 32'd0);
    chk("rh_xfers", 32'(o_xfers), 32'd0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    repeat (6) tick();
    chk("rh_recapture", 32'(o_xfers), 32'd1);
    chk("rh_valid_after", 32'(o_valid), 32'd1);
    chk("rh_data_after", o_data, 32'hA2);
    i_req = 1'b0;
    repeat (6) tick();

    // Random traffic against the model.
    do_reset();
    repeat (3000) begin
      i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) i_req = ~i_req;
      if (!i_req) i_data = $urandom;
      tick();
    end
    i_req = 1'b0;
    repeat (8) tick();

    // Counter wrap: 65537 back-to-back request pulses.
    do_reset();
    i_ready = 1'b1; i_data = 32'hC0DE;
    for (int i = 0; i < 65537; i++) begin
      i_req = 1'b1; tick();
      i_req = 1'b0; tick();
    end
    repeat (4) tick();
    chk("wrap_xfers", 32'(o_xfers), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
